// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR and trap unit: CSR addresses,
// access-op encodings, interrupt cause codes and mstatus bit positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Interrupt cause codes double as mip/mie bit positions.
  localparam int IRQ_SOFT   = 3;
  localparam int IRQ_TIMER  = 7;
  localparam int IRQ_EXT    = 11;
  localparam int IRQ_LOCAL0 = 16;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Addresses with [11:10] == 2'b11 are read-only.
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// CSR access bus between the instruction pipeline (master) and the CSR unit.
interface csr_trap_unit_if #(
  parameter int XLEN = 64
);
  logic            csr_valid_i;
  logic [1:0]      csr_op_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_illegal_o;

  modport master (
    output csr_valid_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_valid_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt selector: ext > soft > timer > local (lowest index first).
module csr_irq_arbiter
  import csr_pkg::*;
#(
  parameter int NUM_LIRQ = 4
) (
  input  logic                pend_soft,
  input  logic                pend_timer,
  input  logic                pend_ext,
  input  logic [NUM_LIRQ-1:0] pend_local,
  output logic [4:0]          code,
  output logic                valid
);

  // Pick the highest-priority pending cause; locals scanned downward so index 0 wins.
  always_comb begin
    valid = 1'b1;
    code  = '0;
    if (pend_ext) begin
      code = 5'(IRQ_EXT);
    end else if (pend_soft) begin
      code = 5'(IRQ_SOFT);
    end else if (pend_timer) begin
      code = 5'(IRQ_TIMER);
    end else begin
      valid = 1'b0;
      for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
        if (pend_local[i]) begin
          valid = 1'b1;
          code  = 5'(IRQ_LOCAL0 + i);
        end
      end
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry, MRET and interrupt arbitration.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int NUM_LIRQ     = 4,
  parameter int HAS_MINSTRET = 1,
  parameter int HARTID       = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  csr_trap_unit_if.slave      csr,
  input  logic                inst_retire_i,
  input  logic                exc_valid_i,
  input  logic [4:0]          exc_cause_i,
  input  logic [XLEN-1:0]     exc_pc_i,
  input  logic [XLEN-1:0]     exc_tval_i,
  input  logic                mret_i,
  input  logic [XLEN-1:0]     commit_pc_i,
  input  logic                irq_soft_i,
  input  logic                irq_timer_i,
  input  logic                irq_ext_i,
  input  logic [NUM_LIRQ-1:0] irq_local_i,
  output logic                redirect_valid_o,
  output logic [XLEN-1:0]     redirect_pc_o,
  output logic                irq_pending_o
);

  localparam logic [XLEN-1:0] ALIGN4     = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b01};

  logic                mst_mie_q, mst_mpie_q, cy_inh_q, ir_inh_q;
  logic [XLEN-1:0]     mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0]     mcycle_q, minstret_q;
  logic                mip_soft_q, mip_timer_q, mip_ext_q;
  logic [NUM_LIRQ-1:0] mip_lirq_q, lirq_prev_q;

  logic [XLEN-1:0] mstatus_rd, mip_rd, minh_rd, irq_mask, rd_val, wval;
  logic [XLEN-1:0] trap_cause, trap_target, trap_pc;
  logic            hit, op_rw, op_sc, wdata_nz, illegal, wen, csr_we;
  logic            exc_take, irq_take, mret_take, trap_take, arb_valid;
  logic [4:0]      arb_code, trap_code;

  // Assemble read views of the sparse registers and the writable mie mask.
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE] = mst_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mst_mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mip_rd = '0;
    mip_rd[IRQ_SOFT] = mip_soft_q;
    mip_rd[IRQ_TIMER] = mip_timer_q;
    mip_rd[IRQ_EXT] = mip_ext_q;
    mip_rd[IRQ_LOCAL0 +: NUM_LIRQ] = mip_lirq_q;
    irq_mask = '0;
    irq_mask[IRQ_SOFT] = 1'b1;
    irq_mask[IRQ_TIMER] = 1'b1;
    irq_mask[IRQ_EXT] = 1'b1;
    irq_mask[IRQ_LOCAL0 +: NUM_LIRQ] = '1;
    minh_rd = '0;
    minh_rd[0] = cy_inh_q;
    minh_rd[2] = ir_inh_q;
  end

  // Address decode: pre-write read value and whether the address exists.
  always_comb begin
    rd_val = '0;
    hit    = 1'b1;
    case (csr.csr_addr_i)
      CSR_MSTATUS:       rd_val = mstatus_rd;
      CSR_MIE:           rd_val = mie_q;
      CSR_MTVEC:         rd_val = mtvec_q;
      CSR_MCOUNTINHIBIT: rd_val = minh_rd;
      CSR_MSCRATCH:      rd_val = mscratch_q;
      CSR_MEPC:          rd_val = mepc_q;
      CSR_MCAUSE:        rd_val = mcause_q;
      CSR_MTVAL:         rd_val = mtval_q;
      CSR_MIP:           rd_val = mip_rd;
      CSR_MCYCLE:        rd_val = mcycle_q;
      CSR_MINSTRET: begin
        if (HAS_MINSTRET != 0) rd_val = minstret_q;
        else hit = 1'b0;
      end
      CSR_MHARTID:       rd_val = XLEN'(HARTID);
      default:           hit = 1'b0;
    endcase
  end

  assign op_rw    = csr.csr_op_i == CSR_OP_RW;
  assign op_sc    = (csr.csr_op_i == CSR_OP_RS) || (csr.csr_op_i == CSR_OP_RC);
  assign wdata_nz = |csr.csr_wdata_i;
  assign wen      = op_rw | (op_sc & wdata_nz);
  assign illegal  = !hit | (csr_is_read_only(csr.csr_addr_i) & wen);

  assign csr.csr_rdata_o   = rd_val;
  assign csr.csr_illegal_o = rst_n & csr.csr_valid_i & illegal;

  // Read-modify-write value before per-register masking.
  always_comb begin
    case (csr.csr_op_i)
      CSR_OP_RW: wval = csr.csr_wdata_i;
      CSR_OP_RS: wval = rd_val | csr.csr_wdata_i;
      CSR_OP_RC: wval = rd_val & ~csr.csr_wdata_i;
      default:   wval = rd_val;
    endcase
  end

  csr_irq_arbiter #(.NUM_LIRQ(NUM_LIRQ)) u_arb (
    .pend_soft  (mip_soft_q & mie_q[IRQ_SOFT]),
    .pend_timer (mip_timer_q & mie_q[IRQ_TIMER]),
    .pend_ext   (mip_ext_q & mie_q[IRQ_EXT]),
    .pend_local (mip_lirq_q & mie_q[IRQ_LOCAL0 +: NUM_LIRQ]),
    .code       (arb_code),
    .valid      (arb_valid)
  );

  assign irq_pending_o = |(mip_rd & mie_q);

  // Exceptions beat interrupts; interrupts wait for a quiet cycle; CSR writes lose to all events.
  assign exc_take  = exc_valid_i;
  assign irq_take  = mst_mie_q & arb_valid & !exc_valid_i & !mret_i & !csr.csr_valid_i;
  assign mret_take = mret_i & !exc_valid_i;
  assign trap_take = exc_take | irq_take;
  assign csr_we    = csr.csr_valid_i & !illegal & wen & !exc_valid_i & !mret_i;
  assign trap_code = exc_take ? exc_cause_i : arb_code;
  assign trap_pc   = exc_take ? exc_pc_i : commit_pc_i;

  // Cause word and vectored/direct trap target.
  always_comb begin
    trap_cause = '0;
    trap_cause[4:0] = trap_code;
    trap_cause[XLEN-1] = irq_take;
    trap_target = mtvec_q & ALIGN4;
    if (mtvec_q[1:0] == 2'b01 && !exc_take) trap_target = (mtvec_q & ALIGN4) + XLEN'({trap_code, 2'b00});
  end

  // Architectural CSR state: trap/MRET updates, CSR writes, interrupt capture, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_q <= 1'b0; mst_mpie_q <= 1'b0; cy_inh_q <= 1'b0; ir_inh_q <= 1'b0;
      mie_q <= '0; mtvec_q <= '0; mscratch_q <= '0; mepc_q <= '0;
      mcause_q <= '0; mtval_q <= '0; mcycle_q <= '0; minstret_q <= '0;
      mip_soft_q <= 1'b0; mip_timer_q <= 1'b0; mip_ext_q <= 1'b0;
      mip_lirq_q <= '0; lirq_prev_q <= '0;
    end else begin
      if (trap_take) begin
        mst_mpie_q <= mst_mie_q;
        mst_mie_q  <= 1'b0;
        mepc_q     <= trap_pc & ALIGN4;
        mcause_q   <= trap_cause;
        mtval_q    <= exc_take ? exc_tval_i : '0;
      end else if (mret_take) begin
        mst_mie_q  <= mst_mpie_q;
        mst_mpie_q <= 1'b1;
      end else if (csr_we) begin
        case (csr.csr_addr_i)
          CSR_MSTATUS: begin
            mst_mie_q  <= wval[MSTATUS_MIE];
            mst_mpie_q <= wval[MSTATUS_MPIE];
          end
          CSR_MEPC:   mepc_q   <= wval & ALIGN4;
          CSR_MCAUSE: mcause_q <= wval;
          CSR_MTVAL:  mtval_q  <= wval;
          default: ;
        endcase
      end
      if (csr_we && csr.csr_addr_i == CSR_MIE) mie_q <= wval & irq_mask;
      if (csr_we && csr.csr_addr_i == CSR_MTVEC) mtvec_q <= wval & MTVEC_MASK;
      if (csr_we && csr.csr_addr_i == CSR_MSCRATCH) mscratch_q <= wval;
      if (csr_we && csr.csr_addr_i == CSR_MCOUNTINHIBIT) begin
        cy_inh_q <= wval[0];
        ir_inh_q <= wval[2];
      end
      // Level lines are sampled one cycle late; local lines latch on a rising edge.
      mip_soft_q  <= irq_soft_i;
      mip_timer_q <= irq_timer_i;
      mip_ext_q   <= irq_ext_i;
      lirq_prev_q <= irq_local_i;
      mip_lirq_q  <= ((csr_we && csr.csr_addr_i == CSR_MIP) ? wval[IRQ_LOCAL0 +: NUM_LIRQ] : mip_lirq_q)
                     | (irq_local_i & ~lirq_prev_q);
      if (csr_we && csr.csr_addr_i == CSR_MCYCLE) mcycle_q <= wval;
      else if (!cy_inh_q) mcycle_q <= mcycle_q + XLEN'(1);
      if (HAS_MINSTRET == 0) minstret_q <= '0;
      else if (csr_we && csr.csr_addr_i == CSR_MINSTRET) minstret_q <= wval;
      else if (inst_retire_i && !ir_inh_q) minstret_q <= minstret_q + XLEN'(1);
    end
  end

  // One-cycle redirect pulse; the target holds until the next redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      redirect_valid_o <= trap_take | mret_take;
      if (trap_take) redirect_pc_o <= trap_target;
      else if (mret_take) redirect_pc_o <= mepc_q;
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: CSR access, traps, MRET, counters, reset.
module tb_csr_trap_unit;
  import csr_pkg::*;

  localparam int XLEN     = 64;
  localparam int NUM_LIRQ = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                inst_retire_i = 1'b0;
  logic                exc_valid_i = 1'b0;
  logic [4:0]          exc_cause_i = '0;
  logic [XLEN-1:0]     exc_pc_i = '0;
  logic [XLEN-1:0]     exc_tval_i = '0;
  logic                mret_i = 1'b0;
  logic [XLEN-1:0]     commit_pc_i = 64'h400;
  logic                irq_soft_i = 1'b0;
  logic                irq_timer_i = 1'b0;
  logic                irq_ext_i = 1'b0;
  logic [NUM_LIRQ-1:0] irq_local_i = '0;
  logic                redirect_valid_o;
  logic [XLEN-1:0]     redirect_pc_o;
  logic                irq_pending_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] rd;
  logic            ill;

  csr_trap_unit_if #(.XLEN(XLEN)) bus ();

  csr_trap_unit #(.XLEN(XLEN), .NUM_LIRQ(NUM_LIRQ), .HAS_MINSTRET(1), .HARTID(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .csr              (bus),
    .inst_retire_i    (inst_retire_i),
    .exc_valid_i      (exc_valid_i),
    .exc_cause_i      (exc_cause_i),
    .exc_pc_i         (exc_pc_i),
    .exc_tval_i       (exc_tval_i),
    .mret_i           (mret_i),
    .commit_pc_i      (commit_pc_i),
    .irq_soft_i       (irq_soft_i),
    .irq_timer_i      (irq_timer_i),
    .irq_ext_i        (irq_ext_i),
    .irq_local_i      (irq_local_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .irq_pending_o    (irq_pending_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_op(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd,
                        output logic [63:0] rdata, output logic illegal);
    bus.csr_valid_i = 1'b1;
    bus.csr_op_i    = op;
    bus.csr_addr_i  = addr;
    bus.csr_wdata_i = wd;
    #1;
    rdata   = bus.csr_rdata_o;
    illegal = bus.csr_illegal_o;
    step();
    bus.csr_valid_i = 1'b0;
    bus.csr_op_i    = 2'b00;
    bus.csr_wdata_i = '0;
  endtask

  task automatic csr_rd(input logic [11:0] addr, output logic [63:0] rdata);
    logic dummy;
    csr_op(CSR_OP_RS, addr, 64'h0, rdata, dummy);
  endtask

  initial begin
    bus.csr_valid_i = 1'b0;
    bus.csr_op_i    = 2'b00;
    bus.csr_addr_i  = '0;
    bus.csr_wdata_i = '0;
    step();
    step();
    check_val("rst_redirect_valid", 64'(redirect_valid_o), 64'd0);
    check_val("rst_redirect_pc", redirect_pc_o, 64'd0);
    check_val("rst_irq_pending", 64'(irq_pending_o), 64'd0);
    check_val("rst_illegal", 64'(bus.csr_illegal_o), 64'd0);
    rst_n = 1'b1;
    step();

    // mstatus set-bits returns the pre-write value
    csr_op(CSR_OP_RS, CSR_MSTATUS, 64'h8, rd, ill);
    check_val("mstatus_rs_old", rd, 64'h1800);
    csr_rd(CSR_MSTATUS, rd);
    check_val("mstatus_rs_new", rd, 64'h1808);

    // mtvec bit1 is not writable
    csr_op(CSR_OP_RW, CSR_MTVEC, 64'h1003, rd, ill);
    check_val("mtvec_old", rd, 64'h0);
    csr_rd(CSR_MTVEC, rd);
    check_val("mtvec_warl", rd, 64'h1001);
    csr_op(CSR_OP_RW, CSR_MIE, 64'h80, rd, ill);

    // Vectored timer interrupt
    irq_timer_i = 1'b1;
    step();
    check_val("timer_pending", 64'(irq_pending_o), 64'd1);
    check_val("timer_no_redirect_yet", 64'(redirect_valid_o), 64'd0);
    step();
    irq_timer_i = 1'b0;
    check_val("timer_redirect_valid", 64'(redirect_valid_o), 64'd1);
    check_val("timer_redirect_pc", redirect_pc_o, 64'h101C);
    step();
    check_val("timer_pulse_end", 64'(redirect_valid_o), 64'd0);
    check_val("timer_pc_hold", redirect_pc_o, 64'h101C);
    csr_rd(CSR_MCAUSE, rd);
    check_val("timer_mcause", rd, 64'h8000_0000_0000_0007);
    csr_rd(CSR_MSTATUS, rd);
    check_val("timer_mstatus", rd, 64'h1880);
    csr_rd(CSR_MEPC, rd);
    check_val("timer_mepc", rd, 64'h400);
    csr_rd(CSR_MTVAL, rd);
    check_val("timer_mtval", rd, 64'h0);

    // A CSR write in the same cycle as an exception is dropped
    csr_op(CSR_OP_RW, CSR_MSCRATCH, 64'h11, rd, ill);
    bus.csr_valid_i = 1'b1;
    bus.csr_op_i    = CSR_OP_RW;
    bus.csr_addr_i  = CSR_MSCRATCH;
    bus.csr_wdata_i = 64'hAA;
    exc_valid_i = 1'b1; exc_cause_i = 5'd5; exc_pc_i = 64'h300; exc_tval_i = 64'h0;
    step();
    bus.csr_valid_i = 1'b0; bus.csr_op_i = 2'b00; bus.csr_wdata_i = '0;
    exc_valid_i = 1'b0;
    check_val("drop_redirect_pc", redirect_pc_o, 64'h1000);
    csr_rd(CSR_MSCRATCH, rd);
    check_val("drop_mscratch", rd, 64'h11);

    // Exception beats a pending, enabled interrupt
    irq_timer_i = 1'b1;
    step();
    check_val("exc_irq_pending", 64'(irq_pending_o), 64'd1);
    csr_op(CSR_OP_RS, CSR_MSTATUS, 64'h8, rd, ill);
    check_val("exc_mstatus_old", rd, 64'h1800);
    exc_valid_i = 1'b1; exc_cause_i = 5'd2; exc_pc_i = 64'h200; exc_tval_i = 64'h55;
    irq_timer_i = 1'b0;
    step();
    exc_valid_i = 1'b0;
    check_val("exc_redirect_valid", 64'(redirect_valid_o), 64'd1);
    check_val("exc_redirect_pc", redirect_pc_o, 64'h1000);
    csr_rd(CSR_MCAUSE, rd);
    check_val("exc_mcause", rd, 64'h2);
    csr_rd(CSR_MEPC, rd);
    check_val("exc_mepc", rd, 64'h200);
    csr_rd(CSR_MTVAL, rd);
    check_val("exc_mtval", rd, 64'h55);
    csr_rd(CSR_MSTATUS, rd);
    check_val("exc_mstatus", rd, 64'h1880);

    // MRET
    csr_op(CSR_OP_RW, CSR_MEPC, 64'h206, rd, ill);
    csr_rd(CSR_MEPC, rd);
    check_val("mepc_warl", rd, 64'h204);
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    check_val("mret_redirect_valid", 64'(redirect_valid_o), 64'd1);
    check_val("mret_redirect_pc", redirect_pc_o, 64'h204);
    step();
    check_val("mret_pulse_end", 64'(redirect_valid_o), 64'd0);
    csr_rd(CSR_MSTATUS, rd);
    check_val("mret_mstatus", rd, 64'h1888);

    // mcycle wrap
    csr_op(CSR_OP_RW, CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF, rd, ill);
    bus.csr_valid_i = 1'b1; bus.csr_op_i = CSR_OP_RS; bus.csr_addr_i = CSR_MCYCLE; bus.csr_wdata_i = '0;
    #1;
    check_val("mcycle_ones", bus.csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check_val("mcycle_wrap0", bus.csr_rdata_o, 64'h0);
    step();
    check_val("mcycle_wrap1", bus.csr_rdata_o, 64'h1);
    bus.csr_valid_i = 1'b0;

    // Counter inhibit
    csr_op(CSR_OP_RW, CSR_MCOUNTINHIBIT, 64'hFF, rd, ill);
    csr_rd(CSR_MCOUNTINHIBIT, rd);
    check_val("minh_mask", rd, 64'h5);
    inst_retire_i = 1'b1;
    step(); step(); step();
    inst_retire_i = 1'b0;
    csr_rd(CSR_MINSTRET, rd);
    check_val("minstret_inhibited", rd, 64'h0);
    csr_op(CSR_OP_RW, CSR_MCOUNTINHIBIT, 64'h1, rd, ill);
    inst_retire_i = 1'b1;
    step(); step(); step();
    inst_retire_i = 1'b0;
    csr_rd(CSR_MINSTRET, rd);
    check_val("minstret_count", rd, 64'h3);
    csr_op(CSR_OP_RW, CSR_MCYCLE, 64'h10, rd, ill);
    csr_rd(CSR_MCYCLE, rd);
    check_val("mcycle_hold_a", rd, 64'h10);
    csr_rd(CSR_MCYCLE, rd);
    check_val("mcycle_hold_b", rd, 64'h10);

    // Local interrupt edge capture and clear
    csr_op(CSR_OP_RW, CSR_MSTATUS, 64'h0, rd, ill);
    check_val("lirq_mstatus_old", rd, 64'h1888);
    csr_op(CSR_OP_RW, CSR_MIE, 64'h10000, rd, ill);
    irq_local_i = 4'b0001;
    step();
    irq_local_i = 4'b0000;
    check_val("lirq_pending", 64'(irq_pending_o), 64'd1);
    csr_rd(CSR_MIP, rd);
    check_val("lirq_mip_sticky", rd, 64'h10000);
    csr_op(CSR_OP_RC, CSR_MIP, 64'h10000, rd, ill);
    check_val("lirq_rc_old", rd, 64'h10000);
    csr_rd(CSR_MIP, rd);
    check_val("lirq_mip_clear", rd, 64'h0);
    check_val("lirq_not_pending", 64'(irq_pending_o), 64'd0);

    // Lowest local index wins
    csr_op(CSR_OP_RW, CSR_MIE, 64'h30000, rd, ill);
    irq_local_i = 4'b0011;
    step();
    irq_local_i = 4'b0000;
    csr_op(CSR_OP_RS, CSR_MSTATUS, 64'h8, rd, ill);
    step();
    check_val("lprio_redirect_valid", 64'(redirect_valid_o), 64'd1);
    check_val("lprio_redirect_pc", redirect_pc_o, 64'h1040);
    csr_rd(CSR_MCAUSE, rd);
    check_val("lprio_mcause", rd, 64'h8000_0000_0000_0010);

    // Illegal accesses
    csr_op(CSR_OP_RW, CSR_MHARTID, 64'h5, rd, ill);
    check_val("hartid_rw_illegal", 64'(ill), 64'd1);
    csr_op(CSR_OP_RS, CSR_MHARTID, 64'h1, rd, ill);
    check_val("hartid_rs_illegal", 64'(ill), 64'd1);
    csr_op(CSR_OP_RS, CSR_MHARTID, 64'h0, rd, ill);
    check_val("hartid_read_legal", 64'(ill), 64'd0);
    check_val("hartid_value", rd, 64'h3);
    csr_op(CSR_OP_RS, 12'h7C0, 64'h0, rd, ill);
    check_val("unimpl_illegal", 64'(ill), 64'd1);
    check_val("unimpl_rdata", rd, 64'h0);

    // Asynchronous reset aborts a pending MRET redirect
    mret_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_redirect_valid", 64'(redirect_valid_o), 64'd0);
    check_val("arst_redirect_pc", redirect_pc_o, 64'h0);
    check_val("arst_irq_pending", 64'(irq_pending_o), 64'd0);
    step();
    mret_i = 1'b0;
    check_val("arst_no_pulse", 64'(redirect_valid_o), 64'd0);
    rst_n = 1'b1;
    csr_rd(CSR_MSTATUS, rd);
    check_val("arst_mstatus", rd, 64'h1800);
    csr_rd(CSR_MIE, rd);
    check_val("arst_mie", rd, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
